fft_rd_arbiter: RTL and testbench
=================================

Name: fft_rd_arbiter

Overview:
- Shares the single read port of the FFT symbol RAM between two requesters: the DMRS-index reader (channel estimation) and the PBCH-index reader (equalization).
- Replaces the fixed select-line mux/demux/flop arrangement in the post-FFT path with request/grant arbitration: round-robin, burst-locked.
- Tracks the fixed RAM read latency and routes each returned I/Q word to the requester that issued it, with a valid pulse.

Parameters:
- ADDR_WIDTH, 10, FFT RAM address width.
- RX_WORD_LENGTH, 12, width of each of the I and Q sample words.
- RD_LATENCY, 1, RAM cycles from address to data (legal range 1..4).
- MAX_BURST, 8, maximum consecutive grants to one owner while the other requester waits (legal range 1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  abort pulse: drops all in-flight reads.
- dmrs_req  in  1  DMRS read request.
- dmrs_addr  in  ADDR_WIDTH  DMRS read address.
- dmrs_gnt  out  1  DMRS request accepted this cycle.
- dmrs_rvld  out  1  DMRS read data valid (1-cycle pulse).
- dmrs_rdata_i / dmrs_rdata_q  out  RX_WORD_LENGTH each  DMRS read data.
- pbch_req / pbch_addr / pbch_gnt / pbch_rvld / pbch_rdata_i / pbch_rdata_q: same as the DMRS set, for PBCH.
- mem_rd_en  out  1  RAM read enable.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_data_i / mem_data_q  in  RX_WORD_LENGTH each  signed RAM read data.
- busy  out  1  an owner is held or a read is in flight.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - All of these are 0: gnt, rvld, rdata, mem_rd_en, mem_addr, busy.
  - FSM = IDLE, burst_cnt = 0, last_served = PBCH, so DMRS wins the first tie.
- FSM states: IDLE, OWN_DMRS, OWN_PBCH. The state is registered; grant decode is combinational from state and the req inputs.
- Grant rules, evaluated every cycle:
  - IDLE, one requester high: grant it.
  - IDLE, both high: grant the one that is not last_served.
  - OWN_X with req_X high and (burst_cnt < MAX_BURST or other req low): grant X.
  - OWN_X with burst_cnt == MAX_BURST and other req high: grant the other in this same cycle. No bubble.
  - OWN_X with req_X low: grant the other if it is requesting, else no grant.
- Next state:
  - Granted requester Y: go to OWN_Y. burst_cnt = 1 on an ownership change, else burst_cnt+1, saturating at MAX_BURST. last_served = Y.
  - No grant: go to IDLE, burst_cnt = 0.
- Grant semantics:
  - gnt_X is combinational, and at most one gnt is high per cycle.
  - A transfer occurs when req_X && gnt_X.
  - mem_rd_en = dmrs_gnt | pbch_gnt. mem_addr = addr of the granted requester, else holds its last value.
  - Requesters hold req/addr stable until granted.
- Return path:
  - A RD_LATENCY-deep tag pipe carries {valid, owner}.
  - When the pipe head is valid, mem_data is registered into rdata_X and rvld_X is high for one cycle.
  - Total latency is grant cycle + RD_LATENCY + 1.
  - rdata_X holds its value when not valid.
  - Back-to-back grants give back-to-back rvld in grant order. Ordering is strictly preserved across an owner switch.
- flush:
  - Has priority over new requests: no grant in the flush cycle.
  - Clears the tag pipe (no rvld for in-flight reads) and sets FSM = IDLE, burst_cnt = 0. last_served is kept.
  - rdata is not cleared.
- busy = (state != IDLE) | any tag valid.
- Reset mid-operation: identical to the reset values. In-flight data is discarded.
- Data is passed through unmodified; there is no arithmetic on the samples.

Decomposition:
- Shared package (postfft_pkg) holds:
  - owner encoding constants: OWN_NONE = 2'd0, OWN_DMRS = 2'd1, OWN_PBCH = 2'd2;
  - the FSM state encodings;
  - default ADDR_WIDTH and RX_WORD_LENGTH.
- One sub-module, rd_tag_pipe: a parameterized shift register of {valid, owner} with synchronous clear. It is used for latency tracking.

Test Plan:
- Reset, then dmrs_req=1, addr=10'd100 for 1 cycle -> dmrs_gnt=1 that cycle; mem_addr=100, mem_rd_en=1; dmrs_rvld pulses 2 cycles later (RD_LATENCY=1) with rdata equal to the RAM word at address 100; pbch_rvld stays 0.
- Both requesting from the first cycle after reset, MAX_BURST=8 -> DMRS is granted cycles 0..7; PBCH is granted cycles 8..15 with no idle cycle; rvld sequence is 8 DMRS pulses then 8 PBCH pulses.
- DMRS owns the port with burst_cnt=3; dmrs_req drops while pbch_req=1 -> pbch_gnt in that same cycle; burst_cnt=1.
- flush asserted one cycle after a grant (RD_LATENCY=2) -> no rvld for that read; no grant in the flush cycle; busy=0 on the next cycle.
- rst asserted while OWN_PBCH with 2 reads in flight -> the next cycle has all outputs 0, FSM=IDLE; a subsequent tie grants DMRS first.
- Alternating single-cycle requests across RD_LATENCY in 1..4 -> every rvld arrives exactly RD_LATENCY+1 cycles after its grant with the correct owner; there is never a simultaneous dmrs_rvld and pbch_rvld.

Source files
------------

// File: rtl/fft_rd_arbiter_pkg.sv
// Shared encodings for the post-FFT read path: owner tags, arbiter FSM states
// and default datapath widths.
package postfft_pkg;

  localparam int ADDR_WIDTH_DEF     = 10;
  localparam int RX_WORD_LENGTH_DEF = 12;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DMRS = 2'd1;
  localparam logic [1:0] OWN_PBCH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWN_DMRS = 2'd1,
    ST_OWN_PBCH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fft_rd_arbiter_tag_pipe.sv
// Shift register of {valid, owner} tags that follows each RAM read through the
// fixed read latency; clr_i drops every in-flight tag.
module rd_tag_pipe
  import postfft_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       vld_i,
  input  logic [1:0] owner_i,
  output logic       head_vld_o,
  output logic [1:0] head_owner_o,
  output logic       any_vld_o
);

  logic [DEPTH-1:0] vld_q;
  logic [1:0]       owner_q [DEPTH];

  // Tag shift stages with synchronous clear
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) owner_q[i] <= OWN_NONE;
    end else begin
      vld_q[0]   <= vld_i;
      owner_q[0] <= owner_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]   <= vld_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign head_vld_o   = vld_q[DEPTH-1];
  assign head_owner_o = owner_q[DEPTH-1];
  assign any_vld_o    = |vld_q;

endmodule

// File: rtl/fft_rd_arbiter.sv
// Round-robin, burst-locked arbiter sharing the FFT symbol RAM read port between
// the DMRS and PBCH index readers, with tagged routing of returned I/Q words.
module fft_rd_arbiter
  import postfft_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int RX_WORD_LENGTH = RX_WORD_LENGTH_DEF,
  parameter int RD_LATENCY     = 1,
  parameter int MAX_BURST      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             dmrs_req,
  input  logic        [ADDR_WIDTH-1:0]     dmrs_addr,
  output logic                             dmrs_gnt,
  output logic                             dmrs_rvld,
  output logic signed [RX_WORD_LENGTH-1:0] dmrs_rdata_i,
  output logic signed [RX_WORD_LENGTH-1:0] dmrs_rdata_q,
  input  logic                             pbch_req,
  input  logic        [ADDR_WIDTH-1:0]     pbch_addr,
  output logic                             pbch_gnt,
  output logic                             pbch_rvld,
  output logic signed [RX_WORD_LENGTH-1:0] pbch_rdata_i,
  output logic signed [RX_WORD_LENGTH-1:0] pbch_rdata_q,
  output logic                             mem_rd_en,
  output logic        [ADDR_WIDTH-1:0]     mem_addr,
  input  logic signed [RX_WORD_LENGTH-1:0] mem_data_i,
  input  logic signed [RX_WORD_LENGTH-1:0] mem_data_q,
  output logic                             busy
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  arb_state_e            state_q, state_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic [1:0]            last_served_q, last_served_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [1:0]            sel;
  logic                  same_owner;
  logic                  head_vld, any_vld;
  logic [1:0]            head_owner;
  logic                  ret_dmrs, ret_pbch;

  // Grant decision and next arbiter state
  always_comb begin
    sel           = OWN_NONE;
    state_d       = ST_IDLE;
    burst_cnt_d   = 8'd0;
    last_served_d = last_served_q;
    same_owner    = 1'b0;
    if (rst || flush) begin
      sel = OWN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dmrs_req && pbch_req) sel = (last_served_q == OWN_DMRS) ? OWN_PBCH : OWN_DMRS;
          else if (dmrs_req)        sel = OWN_DMRS;
          else if (pbch_req)        sel = OWN_PBCH;
          else                      sel = OWN_NONE;
        end
        ST_OWN_DMRS: begin
          if (dmrs_req && ((burst_cnt_q < MAX_BURST_C) || !pbch_req)) sel = OWN_DMRS;
          else if (pbch_req)                                           sel = OWN_PBCH;
          else                                                         sel = OWN_NONE;
        end
        ST_OWN_PBCH: begin
          if (pbch_req && ((burst_cnt_q < MAX_BURST_C) || !dmrs_req)) sel = OWN_PBCH;
          else if (dmrs_req)                                           sel = OWN_DMRS;
          else                                                         sel = OWN_NONE;
        end
        default: sel = OWN_NONE;
      endcase
    end
    if (sel != OWN_NONE) begin
      same_owner    = ((sel == OWN_DMRS) && (state_q == ST_OWN_DMRS)) ||
                      ((sel == OWN_PBCH) && (state_q == ST_OWN_PBCH));
      state_d       = (sel == OWN_DMRS) ? ST_OWN_DMRS : ST_OWN_PBCH;
      last_served_d = sel;
      if (!same_owner)                       burst_cnt_d = 8'd1;
      else if (burst_cnt_q == MAX_BURST_C)   burst_cnt_d = burst_cnt_q;
      else                                   burst_cnt_d = burst_cnt_q + 8'd1;
    end else begin
      state_d     = ST_IDLE;
      burst_cnt_d = 8'd0;
    end
  end

  // RAM port drive; the address holds its last granted value between grants
  always_comb begin
    dmrs_gnt  = (sel == OWN_DMRS);
    pbch_gnt  = (sel == OWN_PBCH);
    mem_rd_en = dmrs_gnt | pbch_gnt;
    if (dmrs_gnt)      mem_addr = dmrs_addr;
    else if (pbch_gnt) mem_addr = pbch_addr;
    else               mem_addr = addr_hold_q;
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      burst_cnt_q   <= 8'd0;
      last_served_q <= OWN_PBCH;
      addr_hold_q   <= '0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      last_served_q <= last_served_d;
      addr_hold_q   <= mem_addr;
    end
  end

  rd_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clk_i        (clk),
    .clr_i        (rst | flush),
    .vld_i        (mem_rd_en),
    .owner_i      (sel),
    .head_vld_o   (head_vld),
    .head_owner_o (head_owner),
    .any_vld_o    (any_vld)
  );

  // A flush in the same cycle the data returns still drops that read
  assign ret_dmrs = head_vld && !flush && (head_owner == OWN_DMRS);
  assign ret_pbch = head_vld && !flush && (head_owner == OWN_PBCH);

  // Return-path capture and routing
  always_ff @(posedge clk) begin
    if (rst) begin
      dmrs_rvld    <= 1'b0;
      pbch_rvld    <= 1'b0;
      dmrs_rdata_i <= '0;
      dmrs_rdata_q <= '0;
      pbch_rdata_i <= '0;
      pbch_rdata_q <= '0;
    end else begin
      dmrs_rvld <= ret_dmrs;
      pbch_rvld <= ret_pbch;
      if (ret_dmrs) begin
        dmrs_rdata_i <= mem_data_i;
        dmrs_rdata_q <= mem_data_q;
      end
      if (ret_pbch) begin
        pbch_rdata_i <= mem_data_i;
        pbch_rdata_q <= mem_data_q;
      end
    end
  end

  assign busy = (state_q != ST_IDLE) | any_vld;

endmodule

// File: tb/tb_fft_rd_arbiter.sv
// Directed bench for fft_rd_arbiter: four instances with RD_LATENCY 1..4 share
// the same requester stimulus, each fed by its own behavioural RAM.
module tb_fft_rd_arbiter;
  import postfft_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, dmrs_req, pbch_req;
  logic [9:0]  dmrs_addr, pbch_addr;

  logic        dg [4], pg [4], dv [4], pv [4], mre [4], bz [4];
  logic [9:0]  ma [4];
  logic [11:0] dri [4], drq [4], pri [4], prq [4], mdi [4], mdq [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] ram_i(input logic [9:0] a);
    return {2'b10, a} ^ 12'h3C3;
  endfunction

  function automatic logic [11:0] ram_q(input logic [9:0] a);
    return {a, 2'b01};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    logic [9:0] ap_q [4];
    always_ff @(posedge clk) begin
      ap_q[0] <= ma[g];
      for (int k = 1; k < 4; k++) ap_q[k] <= ap_q[k-1];
    end
    assign mdi[g] = ram_i(ap_q[g]);
    assign mdq[g] = ram_q(ap_q[g]);

    fft_rd_arbiter #(.ADDR_WIDTH(10), .RX_WORD_LENGTH(12), .RD_LATENCY(g + 1), .MAX_BURST(8)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dmrs_req(dmrs_req), .dmrs_addr(dmrs_addr), .dmrs_gnt(dg[g]), .dmrs_rvld(dv[g]),
      .dmrs_rdata_i(dri[g]), .dmrs_rdata_q(drq[g]),
      .pbch_req(pbch_req), .pbch_addr(pbch_addr), .pbch_gnt(pg[g]), .pbch_rvld(pv[g]),
      .pbch_rdata_i(pri[g]), .pbch_rdata_q(prq[g]),
      .mem_rd_en(mre[g]), .mem_addr(ma[g]), .mem_data_i(mdi[g]), .mem_data_q(mdq[g]),
      .busy(bz[g])
    );
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; dmrs_req = 1'b0; pbch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected schedule of the tie-burst scenario: owner code and address per grant cycle
  function automatic logic [1:0] burst_owner(input int gc);
    if ((gc >= 0 && gc < 8) || gc == 16) return OWN_DMRS;
    if (gc >= 8 && gc < 16)              return OWN_PBCH;
    return OWN_NONE;
  endfunction

  function automatic logic [9:0] burst_addr(input int gc);
    if (gc >= 8 && gc < 16) return 10'(300 + gc - 8);
    return 10'(200 + ((gc < 8) ? gc : 8));
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dmrs_req = 1'b0; pbch_req = 1'b0;
    dmrs_addr = 10'd0; pbch_addr = 10'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({dg[i], pg[i], dv[i], pv[i], mre[i], bz[i], ma[i], dri[i], drq[i], pri[i], prq[i]} !== 64'd0) begin
        n_err++;
        $display("FAIL reset_values[%0d]: got gnt=%b%b rvld=%b%b en=%b busy=%b addr=%h rdata=%h %h %h %h, want all 0",
                 i, dg[i], pg[i], dv[i], pv[i], mre[i], bz[i], ma[i], dri[i], drq[i], pri[i], prq[i]);
      end
    end
    dmrs_req = 1'b1;
    #1;
    n_cmp++;
    if ({dg[0], mre[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_gnt_gated: got gnt=%b en=%b, want 0 0", dg[0], mre[0]);
    end
    @(negedge clk);
    rst = 1'b0; dmrs_req = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk);
    dmrs_req = 1'b1; dmrs_addr = 10'd100; #1;
    n_cmp++;
    if ({dg[0], pg[0], mre[0], ma[0]} !== {1'b1, 1'b0, 1'b1, 10'd100}) begin
      n_err++;
      $display("FAIL single_grant: got gnt=%b/%b en=%b addr=%0d, want 1/0/1/100", dg[0], pg[0], mre[0], ma[0]);
    end
    @(negedge clk);
    dmrs_req = 1'b0; #1;
    n_cmp++;
    if ({dg[0], mre[0], ma[0], dv[0]} !== {1'b0, 1'b0, 10'd100, 1'b0}) begin
      n_err++;
      $display("FAIL single_hold: got gnt=%b en=%b addr=%0d rvld=%b, want 0 0 100 0", dg[0], mre[0], ma[0], dv[0]);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({dv[0], pv[0], dri[0], drq[0]} !== {1'b1, 1'b0, ram_i(10'd100), ram_q(10'd100)}) begin
      n_err++;
      $display("FAIL single_return: got rvld=%b/%b data=%h/%h, want 1/0 %h/%h",
               dv[0], pv[0], dri[0], drq[0], ram_i(10'd100), ram_q(10'd100));
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({dv[0], dri[0], drq[0]} !== {1'b0, ram_i(10'd100), ram_q(10'd100)}) begin
      n_err++;
      $display("FAIL single_rdata_hold: got rvld=%b data=%h/%h, want 0 %h/%h",
               dv[0], dri[0], drq[0], ram_i(10'd100), ram_q(10'd100));
    end
  endtask

  task automatic test_burst();
    logic [1:0]  eo;
    logic [9:0]  ea;
    logic [25:0] obs, exp_v;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      dmrs_req  = (c < 17);
      pbch_req  = (c < 16);
      dmrs_addr = 10'(200 + ((c < 8) ? c : 8));
      pbch_addr = 10'(300 + ((c < 8) ? 0 : c - 8));
      #1;
      eo = burst_owner(c);
      ea = (c > 16) ? 10'd208 : burst_addr(c);
      n_cmp++;
      if ({dg[0], pg[0], ma[0]} !== {eo == OWN_DMRS, eo == OWN_PBCH, ea}) begin
        n_err++;
        $display("FAIL burst_gnt c=%0d: got gnt=%b/%b addr=%0d, want %b/%b %0d",
                 c, dg[0], pg[0], ma[0], eo == OWN_DMRS, eo == OWN_PBCH, ea);
      end
      for (int i = 0; i < 4; i++) begin
        eo = burst_owner(c - i - 2);
        ea = burst_addr(c - i - 2);
        if (eo == OWN_DMRS)      begin obs = {dv[i], pv[i], dri[i], drq[i]}; exp_v = {2'b10, ram_i(ea), ram_q(ea)}; end
        else if (eo == OWN_PBCH) begin obs = {dv[i], pv[i], pri[i], prq[i]}; exp_v = {2'b01, ram_i(ea), ram_q(ea)}; end
        else                     begin obs = {dv[i], pv[i], 24'd0};          exp_v = 26'd0; end
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL burst_rvld lat=%0d c=%0d: got %h, want %h", i + 1, c, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_switch();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dmrs_req = 1'b1; pbch_req = 1'b1;
      dmrs_addr = 10'(20 + c); pbch_addr = 10'd30;
      #1;
      n_cmp++;
      if ({dg[0], pg[0], ma[0]} !== {1'b1, 1'b0, 10'(20 + c)}) begin
        n_err++;
        $display("FAIL switch_own c=%0d: got gnt=%b/%b addr=%0d, want 1/0 %0d", c, dg[0], pg[0], ma[0], 20 + c);
      end
    end
    @(negedge clk);
    dmrs_req = 1'b0; #1;
    n_cmp++;
    if ({gen_dut[0].u_dut.burst_cnt_q, dg[0], pg[0], ma[0]} !== {8'd3, 1'b0, 1'b1, 10'd30}) begin
      n_err++;
      $display("FAIL switch_gnt: got cnt=%0d gnt=%b/%b addr=%0d, want 3 0/1 30",
               gen_dut[0].u_dut.burst_cnt_q, dg[0], pg[0], ma[0]);
    end
    @(negedge clk);
    pbch_req = 1'b0; #1;
    n_cmp++;
    if (gen_dut[0].u_dut.burst_cnt_q !== 8'd1) begin
      n_err++;
      $display("FAIL switch_cnt: got %0d, want 1", gen_dut[0].u_dut.burst_cnt_q);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    @(negedge clk);
    dmrs_req = 1'b1; dmrs_addr = 10'd50; #1;
    n_cmp++;
    if (dg[1] !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre_gnt: got %b, want 1", dg[1]);
    end
    @(negedge clk);
    dmrs_req = 1'b0; pbch_req = 1'b1; pbch_addr = 10'd60; flush = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({dg[i], pg[i], mre[i]} !== 3'b000) begin
        n_err++;
        $display("FAIL flush_no_gnt[%0d]: got gnt=%b/%b en=%b, want 0/0 0", i, dg[i], pg[i], mre[i]);
      end
    end
    @(negedge clk);
    flush = 1'b0; pbch_req = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bz[i] !== 1'b0) begin
        n_err++;
        $display("FAIL flush_busy[%0d]: got %b, want 0", i, bz[i]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if ({dv[i], pv[i]} !== 2'b00) begin
          n_err++;
          $display("FAIL flush_no_rvld[%0d] c=%0d: got %b%b, want 00", i, c, dv[i], pv[i]);
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      pbch_req = 1'b1; pbch_addr = 10'(600 + c);
    end
    @(negedge clk);
    rst = 1'b1; #1;
    n_cmp++;
    if ({dg[1], pg[1], mre[1], bz[1]} !== 4'b0001) begin
      n_err++;
      $display("FAIL rstmid_gated: got gnt=%b/%b en=%b busy=%b, want 0/0 0 1", dg[1], pg[1], mre[1], bz[1]);
    end
    @(negedge clk);
    rst = 1'b0; pbch_req = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({dg[i], pg[i], dv[i], pv[i], mre[i], bz[i], ma[i], dri[i], drq[i], pri[i], prq[i]} !== 64'd0) begin
        n_err++;
        $display("FAIL rstmid_outputs[%0d]: got rvld=%b%b busy=%b addr=%h rdata=%h %h %h %h, want all 0",
                 i, dv[i], pv[i], bz[i], ma[i], dri[i], drq[i], pri[i], prq[i]);
      end
    end
    n_cmp++;
    if (gen_dut[1].u_dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL rstmid_state: got %0d, want IDLE", gen_dut[1].u_dut.state_q);
    end
    @(negedge clk);
    dmrs_req = 1'b1; pbch_req = 1'b1; dmrs_addr = 10'd700; pbch_addr = 10'd701; #1;
    n_cmp++;
    if ({dg[1], pg[1], ma[1]} !== {1'b1, 1'b0, 10'd700}) begin
      n_err++;
      $display("FAIL rstmid_tie: got gnt=%b/%b addr=%0d, want 1/0 700", dg[1], pg[1], ma[1]);
    end
    @(negedge clk);
    dmrs_req = 1'b0; pbch_req = 1'b0;
  endtask

  task automatic test_alternating();
    logic [25:0] obs, exp_v;
    logic [9:0]  ea;
    int          gc;
    apply_reset();
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      dmrs_req  = (c < 10) && (c % 2 == 0);
      pbch_req  = (c < 10) && (c % 2 == 1);
      dmrs_addr = 10'(400 + c);
      pbch_addr = 10'(500 + c);
      #1;
      n_cmp++;
      if ({dg[0], pg[0]} !== {dmrs_req, pbch_req}) begin
        n_err++;
        $display("FAIL alt_gnt c=%0d: got %b%b, want %b%b", c, dg[0], pg[0], dmrs_req, pbch_req);
      end
      for (int i = 0; i < 4; i++) begin
        gc = c - i - 2;
        if (gc >= 0 && gc < 10 && gc % 2 == 0) begin
          ea = 10'(400 + gc); obs = {dv[i], pv[i], dri[i], drq[i]}; exp_v = {2'b10, ram_i(ea), ram_q(ea)};
        end else if (gc >= 0 && gc < 10) begin
          ea = 10'(500 + gc); obs = {dv[i], pv[i], pri[i], prq[i]}; exp_v = {2'b01, ram_i(ea), ram_q(ea)};
        end else begin
          obs = {dv[i], pv[i], 24'd0}; exp_v = 26'd0;
        end
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL alt_rvld lat=%0d c=%0d: got %h, want %h", i + 1, c, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_switch();
    test_flush();
    test_reset_mid();
    test_alternating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
